// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - registered N-master to 1-slave bus arbiter with watchdog
module bus_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int RR_MODE     = 1,
   parameter int TIMEOUT     = 255
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_MASTERS-1:0]            m_req_valid,
   input  logic [NUM_MASTERS-1:0]            m_req_we,
   input  logic [NUM_MASTERS*ADDR_W-1:0]     m_req_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0]     m_req_data,
   input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_req_mask,
   output logic [NUM_MASTERS-1:0]            m_res_valid,
   output logic                              m_res_err,
   output logic [DATA_W-1:0]                 m_res_data,
   input  logic                              i_bus_rd_valid,
   input  logic                              i_bus_wr_valid,
   input  logic [DATA_W-1:0]                 i_bus_data,
   output logic                              o_bus_rd,
   output logic                              o_bus_wr,
   output logic [ADDR_W-1:0]                 o_bus_addr,
   output logic [DATA_W/8-1:0]               o_bus_wrmask,
   output logic [DATA_W-1:0]                 o_bus_data
);

   localparam int MASK_W = DATA_W / 8;
   localparam int PTR_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TMR_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] gnt_idx;
   logic [TMR_W-1:0] timer;

   int               lo_i;
   int               hi_i;
   int               win_i;
   int               nxt_ptr;
   logic             lo_found;
   logic             hi_found;
   logic             win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic [MASK_W-1:0] win_mask;
   logic             bus_done;
   logic             bus_tmo;

   // lo_* is the lowest requester overall; hi_* the lowest at or above the rr pointer,
   // so round-robin prefers hi_* and wraps to lo_* when nothing sits above the pointer.
   always_comb begin
      lo_found = 1'b0;
      hi_found = 1'b0;
      lo_i     = 0;
      hi_i     = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (m_req_valid[i] && !lo_found) begin
            lo_found = 1'b1;
            lo_i     = i;
         end
         if (m_req_valid[i] && (i >= int'(rr_ptr)) && !hi_found) begin
            hi_found = 1'b1;
            hi_i     = i;
         end
      end
      win_i   = ((RR_MODE != 0) && hi_found) ? hi_i : lo_i;
      nxt_ptr = (win_i == NUM_MASTERS - 1) ? 0 : win_i + 1;

      win_we   = 1'b0;
      win_addr = '0;
      win_data = '0;
      win_mask = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (i == win_i) begin
            win_we   = m_req_we[i];
            win_addr = m_req_addr[i*ADDR_W +: ADDR_W];
            win_data = m_req_data[i*DATA_W +: DATA_W];
            win_mask = m_req_mask[i*MASK_W +: MASK_W];
         end
      end
   end

   // The strobe for the other direction is deliberately ignored.
   assign bus_done = o_bus_wr ? i_bus_wr_valid : i_bus_rd_valid;
   assign bus_tmo  = (TIMEOUT != 0) && (timer == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         rr_ptr       <= '0;
         gnt_idx      <= '0;
         timer        <= '0;
         m_res_valid  <= '0;
         m_res_err    <= 1'b0;
         m_res_data   <= '0;
         o_bus_rd     <= 1'b0;
         o_bus_wr     <= 1'b0;
         o_bus_addr   <= '0;
         o_bus_wrmask <= '0;
         o_bus_data   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               m_res_valid <= '0;
               m_res_err   <= 1'b0;
               m_res_data  <= '0;
               timer       <= '0;
               if (lo_found) begin
                  gnt_idx      <= PTR_W'(win_i);
                  o_bus_rd     <= ~win_we;
                  o_bus_wr     <= win_we;
                  o_bus_addr   <= win_addr;
                  o_bus_wrmask <= win_we ? win_mask : '0;
                  o_bus_data   <= win_we ? win_data : '0;
                  if (RR_MODE != 0) begin
                     rr_ptr <= PTR_W'(nxt_ptr);
                  end
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               timer <= timer + 1'b1;
               // A completion in the watchdog's last cycle still counts as success.
               if (bus_done || bus_tmo) begin
                  m_res_valid  <= NUM_MASTERS'(1) << gnt_idx;
                  m_res_err    <= ~bus_done;
                  m_res_data   <= (bus_done && o_bus_rd) ? i_bus_data : '0;
                  o_bus_rd     <= 1'b0;
                  o_bus_wr     <= 1'b0;
                  o_bus_addr   <= '0;
                  o_bus_wrmask <= '0;
                  o_bus_data   <= '0;
                  state        <= ST_RESP;
               end
            end
            ST_RESP: begin
               m_res_valid <= '0;
               m_res_err   <= 1'b0;
               m_res_data  <= '0;
               timer       <= '0;
               state       <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized scoreboard bench for bus_arbiter
module tb_bus_arbiter;

   localparam int N   = 3;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int MW  = DW / 8;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [N-1:0]    m_req_valid = '0;
   logic [N-1:0]    m_req_we = '0;
   logic [N*AW-1:0] m_req_addr = '0;
   logic [N*DW-1:0] m_req_data = '0;
   logic [N*MW-1:0] m_req_mask = '0;
   logic [N-1:0]    m_res_valid;
   logic            m_res_err;
   logic [DW-1:0]   m_res_data;
   logic            i_bus_rd_valid = 1'b0;
   logic            i_bus_wr_valid = 1'b0;
   logic [DW-1:0]   i_bus_data = '0;
   logic            o_bus_rd, o_bus_wr;
   logic [AW-1:0]   o_bus_addr;
   logic [MW-1:0]   o_bus_wrmask;
   logic [DW-1:0]   o_bus_data;

   bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req_valid(m_req_valid), .m_req_we(m_req_we), .m_req_addr(m_req_addr),
      .m_req_data(m_req_data), .m_req_mask(m_req_mask),
      .m_res_valid(m_res_valid), .m_res_err(m_res_err), .m_res_data(m_res_data),
      .i_bus_rd_valid(i_bus_rd_valid), .i_bus_wr_valid(i_bus_wr_valid), .i_bus_data(i_bus_data),
      .o_bus_rd(o_bus_rd), .o_bus_wr(o_bus_wr), .o_bus_addr(o_bus_addr),
      .o_bus_wrmask(o_bus_wrmask), .o_bus_data(o_bus_data)
   );

   // Fixed-priority instance with the watchdog disabled and a zero-wait slave.
   logic [N-1:0]    fp_req_valid = '0;
   logic [N*AW-1:0] fp_req_addr = {32'h300, 32'h200, 32'h100};
   logic [N-1:0]    fp_res_valid;
   logic            fp_res_err;
   logic [DW-1:0]   fp_res_data;
   logic            fp_stall = 1'b0;
   logic            fp_bus_rd, fp_bus_wr;
   logic [AW-1:0]   fp_bus_addr;
   logic [MW-1:0]   fp_bus_wrmask;
   logic [DW-1:0]   fp_bus_data;
   logic            fp_rd_valid, fp_wr_valid;
   assign fp_rd_valid = fp_bus_rd & ~fp_stall;
   assign fp_wr_valid = fp_bus_wr & ~fp_stall;

   bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m_req_valid(fp_req_valid), .m_req_we('0), .m_req_addr(fp_req_addr),
      .m_req_data('0), .m_req_mask('0),
      .m_res_valid(fp_res_valid), .m_res_err(fp_res_err), .m_res_data(fp_res_data),
      .i_bus_rd_valid(fp_rd_valid), .i_bus_wr_valid(fp_wr_valid), .i_bus_data(32'hCAFE0000),
      .o_bus_rd(fp_bus_rd), .o_bus_wr(fp_bus_wr), .o_bus_addr(fp_bus_addr),
      .o_bus_wrmask(fp_bus_wrmask), .o_bus_data(fp_bus_data)
   );

   typedef struct {
      logic [N-1:0]  oh;
      logic          err;
      logic [DW-1:0] data;
      int            cyc;
   } resp_t;

   typedef struct {
      logic [69:0]   cmd;
      int            cyc;
      int            lat;
      logic [DW-1:0] rdata;
   } bus_t;

   resp_t resp_q[$];
   bus_t  bus_q[$];

   int checks = 0;
   int errors = 0;
   int rr_ptr_m = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic raise(input int i);
      m_req_valid[i]            = 1'b1;
      m_req_we[i]               = 1'($urandom_range(0, 1));
      m_req_addr[i*AW +: AW]    = $urandom;
      m_req_data[i*DW +: DW]    = $urandom;
      m_req_mask[i*MW +: MW]    = MW'($urandom);
   endtask

   // Reference: round-robin search from the model pointer over currently asserted requests.
   task automatic start_txn(input int lat, output int w);
      bus_t  b;
      resp_t r;
      logic  we;
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && m_req_valid[(rr_ptr_m + k) % N]) w = (rr_ptr_m + k) % N;
      end
      we      = m_req_we[w];
      b.cmd   = {~we, we, m_req_addr[w*AW +: AW],
                 we ? m_req_mask[w*MW +: MW] : 4'h0,
                 we ? m_req_data[w*DW +: DW] : 32'h0};
      b.cyc   = cyc + 1;
      b.lat   = lat;
      b.rdata = $urandom;
      r.oh    = '0;
      r.oh[w] = 1'b1;
      r.err   = (lat >= TMO);
      r.data  = (!r.err && !we) ? b.rdata : '0;
      r.cyc   = b.cyc + ((lat >= TMO) ? TMO : lat + 1);
      bus_q.push_back(b);
      resp_q.push_back(r);
      rr_ptr_m = (w + 1) % N;
   endtask

   task automatic wait_resp();
      int n = 0;
      while (m_res_valid == '0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL resp_wait: no response within 40 cycles at cycle %0d", cyc);
      end
   endtask

   // Slave model and bus monitor.
   bus_t cur;
   logic slave_act = 1'b0;
   int   scnt = 0;
   always @(negedge clk) begin
      logic act;
      logic fire;
      act = o_bus_rd | o_bus_wr;
      if (!rst_n) begin
         slave_act      = 1'b0;
         i_bus_rd_valid = 1'b0;
         i_bus_wr_valid = 1'b0;
      end else begin
         if (act && !slave_act) begin
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bus_unexpected: strobe with no queued request at cycle %0d", cyc);
               cur.cmd = {o_bus_rd, o_bus_wr, o_bus_addr, o_bus_wrmask, o_bus_data};
               cur.lat = 0;
               cur.rdata = '0;
            end else begin
               cur = bus_q.pop_front();
               check("bus_cmd", 128'({o_bus_rd, o_bus_wr, o_bus_addr, o_bus_wrmask, o_bus_data}), 128'(cur.cmd));
               check("bus_cycle", 128'(cyc), 128'(cur.cyc));
            end
            slave_act = 1'b1;
            scnt = 0;
         end else if (act) begin
            scnt++;
            check("bus_hold", 128'({o_bus_rd, o_bus_wr, o_bus_addr, o_bus_wrmask, o_bus_data}), 128'(cur.cmd));
         end else begin
            slave_act = 1'b0;
            check("bus_idle", 128'({o_bus_addr, o_bus_wrmask, o_bus_data}), 128'(0));
         end
         fire = slave_act && act && (scnt == cur.lat);
         if (slave_act && act) begin
            i_bus_rd_valid = cur.cmd[69] ? fire : 1'($urandom_range(0, 1));
            i_bus_wr_valid = cur.cmd[68] ? fire : 1'($urandom_range(0, 1));
            i_bus_data     = fire ? cur.rdata : $urandom;
         end else begin
            i_bus_rd_valid = 1'b0;
            i_bus_wr_valid = 1'b0;
            i_bus_data     = $urandom;
         end
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      resp_t e;
      if (rst_n) begin
         if (m_res_valid != '0) begin
            if (resp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected: m_res_valid=%b at cycle %0d", m_res_valid, cyc);
            end else begin
               e = resp_q.pop_front();
               check("resp_onehot", 128'(m_res_valid), 128'(e.oh));
               check("resp_err", 128'(m_res_err), 128'(e.err));
               check("resp_data", 128'(m_res_data), 128'(e.data));
               check("resp_cycle", 128'(cyc), 128'(e.cyc));
               check("resp_bus_quiet", 128'({o_bus_rd, o_bus_wr, o_bus_addr}), 128'(0));
            end
         end else begin
            check("resp_idle", 128'({m_res_err, m_res_data}), 128'(0));
         end
      end
   end

   initial begin
      int w;
      int lat;
      int n;
      int last;
      int seen;

      repeat (3) @(negedge clk);
      check("reset_outputs", 128'({m_res_valid, m_res_err, m_res_data, o_bus_rd, o_bus_wr,
                                    o_bus_addr, o_bus_wrmask, o_bus_data}), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int r = 0; r < 60; r++) begin
         for (int i = 0; i < N; i++) begin
            if (!m_req_valid[i] && (r < 8 || $urandom_range(0, 1) == 1)) raise(i);
         end
         if (m_req_valid == '0) raise($urandom_range(0, N - 1));
         lat = (r < 6) ? r : $urandom_range(0, 5);
         start_txn(lat, w);
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) m_req_valid[w] = 1'b0;
         wait_resp();
         m_req_valid[w] = 1'b0;
         @(negedge clk);
      end

      m_req_valid = '0;
      repeat (2) @(negedge clk);
      check("queues_drained", 128'({32'(bus_q.size()), 32'(resp_q.size())}), 128'(0));

      // Reset in the middle of a transaction granted to master 0.
      raise(0);
      start_txn(5, w);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("reset_mid_busy", 128'({m_res_valid, m_res_err, m_res_data, o_bus_rd, o_bus_wr,
                                        o_bus_addr, o_bus_wrmask, o_bus_data}), 128'(0));
      resp_q.delete();
      bus_q.delete();
      rr_ptr_m = 0;
      m_req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) raise(i);
      start_txn(0, w);
      check("post_reset_winner", 128'(w), 128'(0));
      @(negedge clk);
      wait_resp();
      m_req_valid = '0;
      repeat (2) @(negedge clk);

      // Fixed priority: continuous requests all go to master 0, one per 3 cycles.
      fp_req_valid = 3'b111;
      last = 0;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (fp_res_valid == '0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("fp_grant", 128'(fp_res_valid), 128'(3'b001));
         check("fp_resp_data", 128'({fp_res_err, fp_res_data}), 128'(33'h0CAFE0000));
         if (k > 0) check("fp_spacing", 128'(cyc - last), 128'(3));
         last = cyc;
         @(negedge clk);
      end

      // Watchdog disabled: a stalled slave must not produce a response.
      fp_stall = 1'b1;
      seen = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (fp_res_valid != '0) seen++;
      end
      check("fp_no_timeout", 128'({32'(seen), 31'(0), fp_bus_rd}), 128'({32'(0), 31'(0), 1'b1}));
      fp_stall = 1'b0;
      n = 0;
      while (fp_res_valid == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("fp_resume", 128'({fp_res_valid, fp_res_err}), 128'({3'b001, 1'b0}));
      fp_req_valid = '0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
